// File: rtl/ascon_permutation.sv
// Iterative Ascon permutation: one round per clock, 1..MAX_ROUNDS rounds (MAX_ROUNDS <= 16).
// Define ASCON_PERM_BUSY_OUT_EN to add a busy output that is high while a permutation runs.
module ascon_permutation #(
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [4:0]   rounds,
    input  logic [319:0] S,
    output logic [319:0] out,
    output logic         done,
    output logic [4:0]   ctr
`ifdef ASCON_PERM_BUSY_OUT_EN
    ,
    output logic         busy
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [319:0]   x_q, x_d;
    logic [319:0]   out_q, out_d;
    logic           done_q, done_d;
    logic [4:0]     ctr_q, ctr_d;
    logic [4:0]     n_q, n_d;

    logic [4:0]     rounds_eff_s;
    logic [319:0]   round_src_s;
    logic [4:0]     round_i_s;
    logic [4:0]     round_n_s;
    logic [3:0]     rc_idx_s;
    logic [319:0]   round_out_s;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned r);
        return (v >> r) | (v << (64 - r));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, c};
        x3 = s[127:64];
        x4 = s[63:0];
        // Bit-sliced form of the 5-bit S-box, x0 being the MSB of each column
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Round datapath: the start round works on S, later rounds on the held state
    always_comb begin
        if ((rounds == 5'd0) || (int'(rounds) > MAX_ROUNDS)) begin
            rounds_eff_s = 5'(MAX_ROUNDS);
        end else begin
            rounds_eff_s = rounds;
        end
        if (state_q == RUN) begin
            round_src_s = x_q;
            round_i_s   = ctr_q;
            round_n_s   = n_q;
        end else begin
            round_src_s = S;
            round_i_s   = 5'd0;
            round_n_s   = rounds_eff_s;
        end
        // Constant table entry k is {F-k, k}
        rc_idx_s    = 4'(round_i_s + 5'(MAX_ROUNDS) - round_n_s);
        round_out_s = ascon_round(round_src_s, {4'hF - rc_idx_s, rc_idx_s});
    end

    // Next-state logic; a set done_q marks the result cycle in which start is ignored
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        out_d   = out_q;
        done_d  = 1'b0;
        ctr_d   = ctr_q;
        n_d     = n_q;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    n_d   = rounds_eff_s;
                    x_d   = round_out_s;
                    ctr_d = 5'd1;
                    if (rounds_eff_s == 5'd1) begin
                        out_d   = round_out_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    ctr_d = 5'd0;
                end
            end
            RUN: begin
                x_d   = round_out_s;
                ctr_d = ctr_q + 5'd1;
                if ((ctr_q + 5'd1) == n_q) begin
                    out_d   = round_out_s;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                ctr_d   = 5'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= 320'd0;
            out_q   <= 320'd0;
            done_q  <= 1'b0;
            ctr_q   <= 5'd0;
            n_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ctr_q   <= ctr_d;
            n_q     <= n_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;
    assign ctr  = ctr_q;
`ifdef ASCON_PERM_BUSY_OUT_EN
    assign busy = (state_q == RUN);
`endif

endmodule

// File: tb/tb_ascon_permutation.sv
// Randomized bench for ascon_permutation against a table-driven Ascon reference model.
module tb_ascon_permutation;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   rounds;
    logic [319:0] S;
    logic [319:0] out;
    logic         done;
    logic [4:0]   ctr;
`ifdef ASCON_PERM_BUSY_OUT_EN
    logic         busy;
`endif

    int n_vec;
    int n_err;

    localparam logic [7:0] RC_TAB [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                          8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    localparam logic [4:0] SBOX [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                                        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                                        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                                        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    ascon_permutation #(.MAX_ROUNDS(12)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rounds (rounds),
        .S      (S),
        .out    (out),
        .done   (done),
        .ctr    (ctr)
`ifdef ASCON_PERM_BUSY_OUT_EN
        ,
        .busy   (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] v, input int a);
        logic [127:0] d;
        d = {v, v} >> a;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col, sv;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int r = 0; r < n; r++) begin
            x[2][7:0] = x[2][7:0] ^ RC_TAB[r + 12 - n];
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sv  = SBOX[col];
                for (int w = 0; w < 5; w++) y[w][b] = sv[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = y[w] ^ ror(y[w], ROT_A[w]) ^ ror(y[w], ROT_B[w]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        v = 320'd0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom())};
        return v;
    endfunction

    // One permutation with start pulsed for a single edge; checks ctr, latency, out and aftermath
    task automatic run_perm(input logic [319:0] s_in, input logic [4:0] r_in, input bit scramble,
                            output logic [319:0] result);
        int n_eff;
        int k;
        logic [319:0] exp;
        n_eff = ((r_in == 5'd0) || (r_in > 5'd12)) ? 12 : int'(r_in);
        exp   = ref_perm(s_in, n_eff);
        @(negedge clk);
        S      = s_in;
        rounds = r_in;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while ((done !== 1'b1) && (k < 40)) begin
            if (scramble) begin
                S      = rand320();
                rounds = 5'($urandom_range(0, 31));
            end
            check_val("ctr_run", 320'(ctr), 320'(k));
            @(negedge clk);
            k++;
        end
        check_val("done_seen", 320'(done), 320'(1));
        check_val("latency", 320'(k), 320'(n_eff));
        check_val("out", out, exp);
        check_val("ctr_at_done", 320'(ctr), 320'(n_eff));
        result = out;
        @(negedge clk);
        check_val("done_pulse_end", 320'(done), 320'(0));
        check_val("ctr_after_done", 320'(ctr), 320'(0));
        check_val("out_hold", out, exp);
    endtask

    initial begin
        logic [319:0] res, res_r1, res_r0, res_r12, s_fix, exp;
        logic [319:0] s_list [4];
        int k, seen;
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        start  = 1'b1;
        rounds = 5'd12;
        S      = rand320();

        // Reset dominates a held start
        repeat (3) begin
            @(negedge clk);
            check_val("rst_out", out, 320'd0);
            check_val("rst_done", 320'(done), 320'(0));
            check_val("rst_ctr", 320'(ctr), 320'(0));
        end
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_val("idle_ctr", 320'(ctr), 320'(0));

        // Known-answer p12
        run_perm({64'h00400C0000000100, 256'd0}, 5'd12, 1'b0, res);
        check_val("p12_kat", res, {64'hEE9398AADB67F03D, 64'h8BB21831C60F1002, 64'hB48A92DB98D5DA62,
                                   64'h43189921B8F8E3E8, 64'h348FA5C9D525E140});

        // rounds = 1, 0 and 12 on the same state
        s_fix = rand320();
        run_perm(s_fix, 5'd1, 1'b0, res_r1);
        run_perm(s_fix, 5'd0, 1'b0, res_r0);
        run_perm(s_fix, 5'd12, 1'b0, res_r12);
        check_val("r0_eq_r12", res_r0, res_r12);

        // Over-range and assorted round counts
        run_perm(rand320(), 5'd13, 1'b0, res);
        run_perm(rand320(), 5'd31, 1'b0, res);
        run_perm(rand320(), 5'd6, 1'b0, res);
        for (int i = 0; i < 6; i++) run_perm(rand320(), 5'($urandom_range(0, 31)), 1'b0, res);

        // Inputs change during the run
        run_perm(rand320(), 5'd7, 1'b1, res);
        run_perm(rand320(), 5'd12, 1'b1, res);

        // start held for three back-to-back permutations
        for (int p = 0; p < 4; p++) s_list[p] = rand320();
        @(negedge clk);
        S      = s_list[0];
        rounds = 5'd12;
        start  = 1'b1;
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            S = s_list[p + 1];
            for (int c = 1; c <= 11; c++) begin
                check_val("hold_ctr", 320'(ctr), 320'(c));
                check_val("hold_nodone", 320'(done), 320'(0));
                @(negedge clk);
            end
            exp = ref_perm(s_list[p], 12);
            check_val("hold_done", 320'(done), 320'(1));
            check_val("hold_ctr_n", 320'(ctr), 320'(12));
            check_val("hold_out", out, exp);
            if (p == 2) start = 1'b0;
            @(negedge clk);
            check_val("hold_gap_done", 320'(done), 320'(0));
            check_val("hold_gap_ctr", 320'(ctr), 320'(0));
        end

        // Abort at ctr = 5
        @(negedge clk);
        S      = rand320();
        rounds = 5'd12;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while ((ctr !== 5'd5) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        check_val("abort_ctr", 320'(ctr), 320'(5));
        reset = 1'b0;
        @(negedge clk);
        check_val("abort_out", out, 320'd0);
        check_val("abort_ctr_clr", 320'(ctr), 320'(0));
        check_val("abort_done", 320'(done), 320'(0));
        reset = 1'b1;
        seen  = 0;
        repeat (16) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check_val("abort_no_done", 320'(seen), 320'(0));
        run_perm(rand320(), 5'd12, 1'b0, res);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
